// File: rtl/axi_vga_pkg.sv
// rtl/axi_vga_pkg.sv - shared types and decode helpers for the VGA timing generator
// Purpose: timing config struct, FSM state type, frame/line total and region decode.
// Ports: none (package).
package axi_vga_pkg;

  localparam int unsigned VgaCntWidth = 16;
  // Two guard bits so the sum of four fields never overflows.
  localparam int unsigned SumWidth = VgaCntWidth + 2;

  typedef logic [VgaCntWidth-1:0] cnt_t;
  typedef logic [SumWidth-1:0]    sum_t;

  typedef struct packed {
    cnt_t visible;
    cnt_t front;
    cnt_t sync;
    cnt_t back;
  } vga_timing_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timing_fsm_state_t;

  typedef struct packed {
    logic visible;
    logic sync;
  } region_t;

  function automatic sum_t timing_total(vga_timing_t cfg);
    return sum_t'(cfg.visible) + sum_t'(cfg.front) + sum_t'(cfg.sync) + sum_t'(cfg.back);
  endfunction

  // Zero-width fields collapse their region naturally: an empty interval never matches.
  function automatic region_t region_decode(sum_t cnt, vga_timing_t cfg);
    region_t r;
    sum_t    sync_start;
    sum_t    sync_end;
    sync_start = sum_t'(cfg.visible) + sum_t'(cfg.front);
    sync_end   = sync_start + sum_t'(cfg.sync);
    r.visible  = cnt < sum_t'(cfg.visible);
    r.sync     = (cnt >= sync_start) && (cnt < sync_end);
    return r;
  endfunction

endpackage

// File: rtl/axi_vga_sync_counter.sv
// rtl/axi_vga_sync_counter.sv - one raster axis counter (used for both h and v)
// Purpose: counts 0..total-1 on advance, wraps to 0, decodes visible and sync regions.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clear_i         force count to 0 (block not running)
//   advance_i       step the counter this cycle
//   cfg_i           shadowed timing for this axis
//   count_o         current count
//   wrap_o          advancing from the last position this cycle (combinational)
//   visible_o       count inside visible region
//   sync_active_o   count inside sync region
module axi_vga_sync_counter
  import axi_vga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        advance_i,
  input  vga_timing_t cfg_i,
  output sum_t        count_o,
  output logic        wrap_o,
  output logic        visible_o,
  output logic        sync_active_o
);

  sum_t    count_q;
  sum_t    count_d;
  sum_t    total;
  region_t region;

  assign total  = timing_total(cfg_i);
  assign region = region_decode(count_q, cfg_i);

  // ">=" rather than "==" so an all-zero config wraps every step instead of running away.
  assign wrap_o        = advance_i && ((count_q + sum_t'(1)) >= total);
  assign count_o       = count_q;
  assign visible_o     = region.visible;
  assign sync_active_o = region.sync;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wrap_o) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = count_q + sum_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axi_vga_timing_fsm.sv
// rtl/axi_vga_timing_fsm.sv - VGA raster timing generator and pixel sink
// Purpose: generates h/v timing from shadowed config, pulls pixels over valid/ready
//          in the visible region, drives registered RGB and sync pins.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   enable_i                      run raster; low returns to idle
//   h_*_i, v_*_i                  timing fields (visible/front/sync/back)
//   hsync_pol_i, vsync_pol_i      1 = sync pulse active-high
//   red_i, green_i, blue_i        pixel from fetcher
//   valid_i / ready_o             pixel handshake
//   red_o, green_o, blue_o        VGA colour (registered)
//   hsync_o, vsync_o              VGA sync (registered)
//   underflow_o                   sticky: visible pixel needed while valid_i low
module axi_vga_timing_fsm
  import axi_vga_pkg::*;
#(
  parameter int unsigned RedWidth   = 5,
  parameter int unsigned GreenWidth = 6,
  parameter int unsigned BlueWidth  = 5,
  // Must match VgaCntWidth: the shadow struct is sized by the package.
  parameter int unsigned CntWidth   = VgaCntWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [CntWidth-1:0]   h_visible_i,
  input  logic [CntWidth-1:0]   h_front_i,
  input  logic [CntWidth-1:0]   h_sync_i,
  input  logic [CntWidth-1:0]   h_back_i,
  input  logic [CntWidth-1:0]   v_visible_i,
  input  logic [CntWidth-1:0]   v_front_i,
  input  logic [CntWidth-1:0]   v_sync_i,
  input  logic [CntWidth-1:0]   v_back_i,
  input  logic                  hsync_pol_i,
  input  logic                  vsync_pol_i,
  input  logic [RedWidth-1:0]   red_i,
  input  logic [GreenWidth-1:0] green_i,
  input  logic [BlueWidth-1:0]  blue_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [RedWidth-1:0]   red_o,
  output logic [GreenWidth-1:0] green_o,
  output logic [BlueWidth-1:0]  blue_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  underflow_o
);

  timing_fsm_state_t state_q, state_d;

  vga_timing_t h_cfg_q, v_cfg_q, h_cfg_in, v_cfg_in;
  logic        hpol_q, vpol_q;
  logic        load_shadow;

  logic [RedWidth-1:0]   red_q, red_d;
  logic [GreenWidth-1:0] green_q, green_d;
  logic [BlueWidth-1:0]  blue_q, blue_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  underflow_q, underflow_d;

  logic run_en;
  sum_t h_count, v_count;
  logic h_wrap, h_vis, h_sync;
  logic v_wrap, v_vis, v_sync;
  logic unused_counts;

  assign h_cfg_in.visible = h_visible_i;
  assign h_cfg_in.front   = h_front_i;
  assign h_cfg_in.sync    = h_sync_i;
  assign h_cfg_in.back    = h_back_i;
  assign v_cfg_in.visible = v_visible_i;
  assign v_cfg_in.front   = v_front_i;
  assign v_cfg_in.sync    = v_sync_i;
  assign v_cfg_in.back    = v_back_i;

  // Dropping enable_i overrides everything, so counting only happens while both hold.
  assign run_en = (state_q == RUN) && enable_i;

  axi_vga_sync_counter u_h_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (!run_en),
    .advance_i     (run_en),
    .cfg_i         (h_cfg_q),
    .count_o       (h_count),
    .wrap_o        (h_wrap),
    .visible_o     (h_vis),
    .sync_active_o (h_sync)
  );

  axi_vga_sync_counter u_v_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (!run_en),
    .advance_i     (run_en && h_wrap),
    .cfg_i         (v_cfg_q),
    .count_o       (v_count),
    .wrap_o        (v_wrap),
    .visible_o     (v_vis),
    .sync_active_o (v_sync)
  );

  // Raw counts are kept for debug visibility only.
  assign unused_counts = ^{h_count, v_count};

  assign ready_o = (state_q == RUN) && h_vis && v_vis;

  always_comb begin
    state_d     = state_q;
    load_shadow = 1'b0;
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    hsync_d     = ~hsync_pol_i;
    vsync_d     = ~vsync_pol_i;
    underflow_d = underflow_q;
    unique case (state_q)
      IDLE: begin
        underflow_d = 1'b0;
        if (enable_i) begin
          state_d     = RUN;
          load_shadow = 1'b1;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          if (ready_o && valid_i) begin
            red_d   = red_i;
            green_d = green_i;
            blue_d  = blue_i;
          end
          if (ready_o && !valid_i) begin
            underflow_d = 1'b1;
          end
          hsync_d = ~(h_sync ^ hpol_q);
          vsync_d = ~(v_sync ^ vpol_q);
          // v_wrap implies h_wrap: this is the step into hcnt=0, vcnt=0.
          if (v_wrap) begin
            load_shadow = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      h_cfg_q     <= '0;
      v_cfg_q     <= '0;
      hpol_q      <= 1'b0;
      vpol_q      <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      underflow_q <= underflow_d;
      if (load_shadow) begin
        h_cfg_q <= h_cfg_in;
        v_cfg_q <= v_cfg_in;
        hpol_q  <= hsync_pol_i;
        vpol_q  <= vsync_pol_i;
      end
    end
  end

  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign underflow_o = underflow_q;

endmodule

// File: doc/axi_vga_timing_fsm.md
Name: axi_vga_timing_fsm

Overview:
Downstream consumer of the AXI VGA pixel fetcher.
- Generates horizontal and vertical raster timing from programmable porch, sync and visible lengths.
- Pulls pixels from the fetcher over a valid/ready stream during the visible region.
- Drives registered RGB and sync outputs to the VGA pins.
- Timing values come from the register file; shadow copies are captured at frame boundaries.

Parameters:
RedWidth, 5, red channel bits
GreenWidth, 6, green channel bits
BlueWidth, 5, blue channel bits
CntWidth, 16, width of horizontal/vertical counters and timing config fields

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
enable_i  in  1  run raster; low holds block idle
h_visible_i  in  CntWidth  visible pixels per line
h_front_i  in  CntWidth  horizontal front porch, cycles
h_sync_i  in  CntWidth  hsync pulse width, cycles
h_back_i  in  CntWidth  horizontal back porch, cycles
v_visible_i  in  CntWidth  visible lines per frame
v_front_i  in  CntWidth  vertical front porch, lines
v_sync_i  in  CntWidth  vsync pulse width, lines
v_back_i  in  CntWidth  vertical back porch, lines
hsync_pol_i  in  1  1 = hsync active-high
vsync_pol_i  in  1  1 = vsync active-high
red_i  in  RedWidth  pixel from fetcher
green_i  in  GreenWidth  pixel from fetcher
blue_i  in  BlueWidth  pixel from fetcher
valid_i  in  1  pixel valid from fetcher
ready_o  out  1  pixel accepted this cycle
red_o  out  RedWidth  VGA red
green_o  out  GreenWidth  VGA green
blue_o  out  BlueWidth  VGA blue
hsync_o  out  1  VGA hsync
vsync_o  out  1  VGA vsync
underflow_o  out  1  sticky: visible pixel needed but valid_i low

Behaviour:
- Reset: rst_ni is sampled on the clock edge (synchronous, active-low). On reset: counters=0, shadow config=0, RGB outputs=0, ready_o=0, underflow_o=0, hsync_o/vsync_o=0.
- Derived totals: htotal = hvis+hfp+hsync+hbp and vtotal = vvis+vfp+vsync+vbp, computed in CntWidth+2 bits. All comparisons are made against these sums; no overflow is permitted.
- States: IDLE, RUN.
  - IDLE: counters held at 0; RGB=0; syncs at inactive level (= ~pol); ready_o=0.
  - IDLE→RUN: enable_i high; all *_i config captured into shadow registers that cycle.
  - RUN→IDLE: enable_i low; takes effect the next cycle and has priority over everything else.
- Horizontal counter hcnt: counts 0..htotal-1, then wraps to 0.
- Vertical counter vcnt: increments when hcnt wraps; wraps to 0 when vcnt=vtotal-1 and hcnt wraps.
- Shadow config reload: at the wrap to hcnt=0, vcnt=0. This is the only reload point while in RUN.
- Regions, evaluated per counter:
  - visible: cnt < vis
  - sync: vis+front <= cnt < vis+front+sync
  - remainder: blank
- active = h visible AND v visible.
- ready_o = RUN AND active; combinational from registered counters.
  - A pixel is consumed only when valid_i AND ready_o.
  - Pixels are never consumed outside the visible region.
- Output pipeline: one-cycle latency, all outputs registered.
  - hsync_o(t+1) = hsync_region(t) XNOR hsync_pol; vsync_o likewise.
  - RGB(t+1) = pixel(t) if active(t) AND valid_i(t), else 0.
- Underflow: active AND NOT valid_i → black pixel is output and underflow_o is set.
  - underflow_o stays set until enable_i is low (cleared in IDLE) or reset.
  - Counters do not stall on underflow; raster timing is never stretched.
- Zero-width fields are legal for porch/sync (that region is skipped). vis=0 means no active pixels.
- A config change mid-frame has no effect until the next frame start.
- Reset asserted mid-line: all state returns to reset values on that edge.

Decomposition:
- Package axi_vga_pkg:
  - typedef vga_timing_t: struct of visible/front/sync/back, CntWidth each.
  - typedef timing_fsm_state_t: IDLE, RUN.
  - function for region decode.
- One sub-module, axi_vga_sync_counter:
  - Instantiated twice (h, v).
  - Has an advance input.
  - Outputs count, wrap, visible, sync_active.

Test Plan:
1. Config h=4/1/2/1 (htotal 8), v=2/1/1/1 (vtotal 5), pols=1, valid_i tied 1, enable at cycle 0 → ready_o high 4 of every 8 cycles on lines 0-1; hsync_o high output cycles 6-7 of each line (counter 5-6 +1 latency); vsync_o high for line 3; frame repeats every 40 cycles.
2. Same config, red_i = incrementing 0,1,2… per accepted pixel → red_o shows 0..7 across the two visible lines, one cycle after acceptance, 0 in blanking; 8 pixels consumed per frame.
3. Drop valid_i low for one cycle at hcnt=2, vcnt=0 → red_o=0 for that pixel; underflow_o sets and stays 1; hcnt continues without stall; enable_i low then high clears it.
4. hsync_pol_i=0, vsync_pol_i=0 → idle and blank levels of hsync_o/vsync_o are 1; pulses are low with identical timing.
5. Change h_visible_i 4→6 at cycle 10 → first frame unchanged (8-cycle lines), second frame uses 10-cycle lines.
6. Assert rst_ni low at cycle 13 for 1 cycle → next cycle all outputs 0, counters 0; with enable_i high, RUN resumes from hcnt=0, vcnt=0.
